hazard_ctrl_unit: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage datapath, replacing the single-cycle load-use detector. It issues per-latch `flush`/`freeze` and `pc_en` for several hazard sources:
- data-cache misses, instruction-fetch misses and taken branches/jumps;
- load-use hazards with a configurable bubble count;
- multi-cycle EX operations, timed by an internal counter;
- all RAW hazards when forwarding is disabled.

It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl_unit.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: priority-ordered hazard controller for the 5-stage pipeline.
// Drives per-latch flush/freeze and pc_en for cache misses, branches/jumps,
// load-use, multi-cycle EX operations and (optionally) unforwarded RAW hazards.
// Latch index: 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB.
module hazard_ctrl_unit #(
    parameter int REG_W        = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int MULTI_LAT    = 4,
    parameter int FWD_EN       = 1,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    input  logic             memread_ex,
    input  logic             regwr_ex,
    input  logic             regwr_mem,
    input  logic [REG_W-1:0] rd_ex,
    input  logic [REG_W-1:0] rd_mem,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             uses_rt_id,
    input  logic             jump_id,
    input  logic             branch_taken_mem,
    input  logic             mc_start,
    output logic [3:0]       flush,
    output logic [3:0]       freeze,
    output logic             pc_en,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    // cnt counts the remaining MCBUSY cycles after the current one
    localparam int CW = (MULTI_LAT > 1) ? $clog2(MULTI_LAT) : 1;
    localparam logic [CW-1:0] MC_LOAD = CW'(MULTI_LAT - 2);
    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LUSTALL = 2'd1,
        MCBUSY  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic hz_ex;
    logic hz_mem;
    logic lu;
    logic raw;
    logic miss;

    // Register 0 is hard-wired zero, so a write to it never creates a dependency
    assign hz_ex  = (rd_ex != '0) &&
                    ((rd_ex == rs_id) || (uses_rt_id && (rd_ex == rt_id)));
    assign hz_mem = (rd_mem != '0) &&
                    ((rd_mem == rs_id) || (uses_rt_id && (rd_mem == rt_id)));
    assign lu     = memread_ex && hz_ex;
    assign raw    = (FWD_EN == 0) && ((regwr_ex && hz_ex) || (regwr_mem && hz_mem));
    assign miss   = dmem_req && !dhit;

    // Priority chain: the first matching hazard owns the outputs and next state
    always_comb begin
        flush     = 4'b0000;
        freeze    = 4'b0000;
        pc_en     = 1'b1;
        mc_busy   = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        if (RST) begin
            flush = 4'b1111;
            pc_en = 1'b0;
        end else if (miss) begin
            freeze  = 4'b1111;
            pc_en   = 1'b0;
            mc_busy = (state == MCBUSY);
        end else if (branch_taken_mem) begin
            flush     = 4'b0111;
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else if ((state == MCBUSY) || ((state == RUN) && mc_start)) begin
            freeze  = 4'b0011;
            flush   = 4'b0100;
            pc_en   = 1'b0;
            mc_busy = 1'b1;
            if (state == RUN) begin
                state_nxt = MCBUSY;
                cnt_nxt   = MC_LOAD;
            end else if (cnt == '0) begin
                state_nxt = RUN;
            end else begin
                cnt_nxt = cnt - CW'(1);
            end
        end else if ((state == LUSTALL) || ((state == RUN) && (lu || raw))) begin
            freeze = 4'b0001;
            flush  = 4'b0010;
            pc_en  = 1'b0;
            if ((state == RUN) && lu && (LOAD_BUBBLES == 2)) begin
                state_nxt = LUSTALL;
            end else begin
                state_nxt = RUN;
            end
        end else if (jump_id) begin
            flush = 4'b0001;
        end else if (!ihit) begin
            flush = 4'b0001;
            pc_en = 1'b0;
        end
    end

    // State and multi-cycle counter register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != STALL_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: drives two differently configured hazard controllers
// with the same stimulus and compares both against a cycle-level model.
// Config A: LOAD_BUBBLES=1, FWD_EN=1, CNT_W=16. Config B: LOAD_BUBBLES=2, FWD_EN=0, CNT_W=4.
module tb_hazard_ctrl_unit;

    localparam int MULTI_LAT = 4;

    logic       clk;
    logic       RST;
    logic       ihit, dmem_req, dhit, memread_ex, regwr_ex, regwr_mem;
    logic [4:0] rd_ex, rd_mem, rs_id, rt_id;
    logic       uses_rt_id, jump_id, branch_taken_mem, mc_start;

    logic [3:0]  flush_a, freeze_a, flush_b, freeze_b;
    logic        pc_en_a, mc_busy_a, pc_en_b, mc_busy_b;
    logic [15:0] stall_a;
    logic [3:0]  stall_b;

    logic [25:0] got_a, want_a;
    logic [13:0] got_b, want_b;

    int checks = 0;
    int fails  = 0;

    // Model state: busy cycles still owed, pending second load bubble, stall count
    int busy_left[2];
    bit lu_pend[2];
    int stall_m[2];

    assign got_a = {flush_a, freeze_a, pc_en_a, mc_busy_a, stall_a};
    assign got_b = {flush_b, freeze_b, pc_en_b, mc_busy_b, stall_b};

    hazard_ctrl_unit #(.REG_W(5), .LOAD_BUBBLES(1), .MULTI_LAT(MULTI_LAT), .FWD_EN(1), .CNT_W(16)) dut_a (
        .CLK(clk), .RST(RST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .memread_ex(memread_ex), .regwr_ex(regwr_ex), .regwr_mem(regwr_mem),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rs_id(rs_id), .rt_id(rt_id),
        .uses_rt_id(uses_rt_id), .jump_id(jump_id), .branch_taken_mem(branch_taken_mem),
        .mc_start(mc_start), .flush(flush_a), .freeze(freeze_a), .pc_en(pc_en_a),
        .mc_busy(mc_busy_a), .stall_cycles(stall_a)
    );

    hazard_ctrl_unit #(.REG_W(5), .LOAD_BUBBLES(2), .MULTI_LAT(MULTI_LAT), .FWD_EN(0), .CNT_W(4)) dut_b (
        .CLK(clk), .RST(RST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .memread_ex(memread_ex), .regwr_ex(regwr_ex), .regwr_mem(regwr_mem),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rs_id(rs_id), .rt_id(rt_id),
        .uses_rt_id(uses_rt_id), .jump_id(jump_id), .branch_taken_mem(branch_taken_mem),
        .mc_start(mc_start), .flush(flush_b), .freeze(freeze_b), .pc_en(pc_en_b),
        .mc_busy(mc_busy_b), .stall_cycles(stall_b)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // True when the ID instruction reads the given destination register
    function automatic bit hz(input logic [4:0] rd);
        return (rd != 5'd0) && ((rd == rs_id) || (uses_rt_id && (rd == rt_id)));
    endfunction

    // Computes expected outputs for this cycle, then advances the model state
    task automatic model_step();
        logic [3:0] fl, fr;
        logic       pc, bz;
        int         st, lbk, fwdk, maxk;
        bit         lu, raw;
        for (int k = 0; k < 2; k++) begin
            lbk  = (k == 0) ? 1 : 2;
            fwdk = (k == 0) ? 1 : 0;
            maxk = (k == 0) ? 65535 : 15;
            fl = 4'h0; fr = 4'h0; pc = 1'b1; bz = 1'b0;
            st = stall_m[k];
            lu  = memread_ex && hz(rd_ex);
            raw = (fwdk == 0) && ((regwr_ex && hz(rd_ex)) || (regwr_mem && hz(rd_mem)));
            if (RST) begin
                fl = 4'hF; pc = 1'b0;
                busy_left[k] = 0; lu_pend[k] = 1'b0;
            end else if (dmem_req && !dhit) begin
                fr = 4'hF; pc = 1'b0; bz = (busy_left[k] > 0);
            end else if (branch_taken_mem) begin
                fl = 4'h7;
                busy_left[k] = 0; lu_pend[k] = 1'b0;
            end else if (busy_left[k] > 0 || (!lu_pend[k] && mc_start)) begin
                fr = 4'h3; fl = 4'h4; pc = 1'b0; bz = 1'b1;
                busy_left[k] = (busy_left[k] > 0) ? busy_left[k] - 1 : MULTI_LAT - 1;
            end else if (lu_pend[k] || lu || raw) begin
                fr = 4'h1; fl = 4'h2; pc = 1'b0;
                lu_pend[k] = !lu_pend[k] && lu && (lbk == 2);
            end else if (jump_id) begin
                fl = 4'h1;
            end else if (!ihit) begin
                fl = 4'h1; pc = 1'b0;
            end
            if (RST) stall_m[k] = 0;
            else if (!pc && stall_m[k] < maxk) stall_m[k] = stall_m[k] + 1;
            if (k == 0) want_a = {fl, fr, pc, bz, 16'(st)};
            else        want_b = {fl, fr, pc, bz, 4'(st)};
        end
    endtask

    // Quiet pipeline: everything hits, no hazards
    task automatic applyStimulus();
        RST = 1'b0; ihit = 1'b1; dmem_req = 1'b0; dhit = 1'b1;
        memread_ex = 1'b0; regwr_ex = 1'b0; regwr_mem = 1'b0;
        rd_ex = 5'd0; rd_mem = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
        uses_rt_id = 1'b0; jump_id = 1'b0; branch_taken_mem = 1'b0; mc_start = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
        model_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Reset outputs, then reset landing in the middle of a multi-cycle op
    task automatic test_reset();
        for (int i = 0; i < 7; i++) begin
            applyStimulus();
            RST = (i < 2) || (i == 4);
            mc_start = (i == 2) || (i == 4);
            sample();
            checks++;
            if (got_a !== want_a) begin fails++; $display("[TB] FAIL reset A cyc %0d: got %b want %b", i, got_a, want_a); end
            checks++;
            if (got_b !== want_b) begin fails++; $display("[TB] FAIL reset B cyc %0d: got %b want %b", i, got_b, want_b); end
            advance();
        end
    endtask

    // Load-use on rs, then a load to r0 which must not stall
    task automatic test_load_use();
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            if (i == 0) begin memread_ex = 1'b1; rd_ex = 5'd5; rs_id = 5'd5; end
            if (i == 4) begin memread_ex = 1'b1; rd_ex = 5'd0; rs_id = 5'd0; end
            sample();
            checks++;
            if (got_a !== want_a) begin fails++; $display("[TB] FAIL load_use A cyc %0d: got %b want %b", i, got_a, want_a); end
            checks++;
            if (got_b !== want_b) begin fails++; $display("[TB] FAIL load_use B cyc %0d: got %b want %b", i, got_b, want_b); end
            advance();
        end
    endtask

    // Plain multi-cycle op, then one interrupted by a two-cycle data miss
    task automatic test_multi_cycle();
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            mc_start = (i == 0) || (i == 6) || (i == 7);
            if (i == 8 || i == 9) begin dmem_req = 1'b1; dhit = 1'b0; end
            sample();
            checks++;
            if (got_a !== want_a) begin fails++; $display("[TB] FAIL multi_cycle A cyc %0d: got %b want %b", i, got_a, want_a); end
            checks++;
            if (got_b !== want_b) begin fails++; $display("[TB] FAIL multi_cycle B cyc %0d: got %b want %b", i, got_b, want_b); end
            advance();
        end
    endtask

    // Branch in second busy cycle; miss+branch; branch+mc_start; jump+load-use
    task automatic test_branch_abort();
        for (int i = 0; i < 14; i++) begin
            applyStimulus();
            mc_start = (i == 0);
            branch_taken_mem = (i == 1) || (i == 4) || (i == 5) || (i == 7);
            if (i == 4) begin dmem_req = 1'b1; dhit = 1'b0; end
            if (i == 7) mc_start = 1'b1;
            if (i == 9 || i == 10) jump_id = 1'b1;
            if (i == 9) begin memread_ex = 1'b1; rd_ex = 5'd3; rt_id = 5'd3; uses_rt_id = 1'b1; end
            sample();
            checks++;
            if (got_a !== want_a) begin fails++; $display("[TB] FAIL branch_abort A cyc %0d: got %b want %b", i, got_a, want_a); end
            checks++;
            if (got_b !== want_b) begin fails++; $display("[TB] FAIL branch_abort B cyc %0d: got %b want %b", i, got_b, want_b); end
            advance();
        end
    endtask

    // RAW against MEM via rt: stalls only without forwarding, and only if rt is read
    task automatic test_raw();
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            regwr_mem = (i < 4); rd_mem = 5'd7; rt_id = 5'd7;
            uses_rt_id = (i < 2);
            if (i == 4) begin regwr_ex = 1'b1; rd_ex = 5'd9; rs_id = 5'd9; end
            sample();
            checks++;
            if (got_a !== want_a) begin fails++; $display("[TB] FAIL raw A cyc %0d: got %b want %b", i, got_a, want_a); end
            checks++;
            if (got_b !== want_b) begin fails++; $display("[TB] FAIL raw B cyc %0d: got %b want %b", i, got_b, want_b); end
            advance();
        end
    endtask

    // Twenty fetch-miss cycles after a reset: the 4-bit counter must stick at 15
    task automatic test_saturation();
        for (int i = 0; i < 24; i++) begin
            applyStimulus();
            RST  = (i == 0);
            ihit = !(i >= 1 && i <= 20);
            sample();
            checks++;
            if (got_a !== want_a) begin fails++; $display("[TB] FAIL saturation A cyc %0d: got %b want %b", i, got_a, want_a); end
            checks++;
            if (got_b !== want_b) begin fails++; $display("[TB] FAIL saturation B cyc %0d: got %b want %b", i, got_b, want_b); end
            advance();
        end
    endtask

    // Random traffic with small register numbers so dependencies are frequent
    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            RST = ($urandom_range(0, 59) == 0);
            ihit = ($urandom_range(0, 7) != 0);
            dmem_req = $urandom_range(0, 1);
            dhit = ($urandom_range(0, 3) != 0);
            memread_ex = $urandom_range(0, 1);
            regwr_ex = $urandom_range(0, 1);
            regwr_mem = $urandom_range(0, 1);
            rd_ex = 5'($urandom_range(0, 5));
            rd_mem = 5'($urandom_range(0, 5));
            rs_id = 5'($urandom_range(0, 5));
            rt_id = 5'($urandom_range(0, 5));
            uses_rt_id = $urandom_range(0, 1);
            jump_id = ($urandom_range(0, 7) == 0);
            branch_taken_mem = ($urandom_range(0, 9) == 0);
            mc_start = ($urandom_range(0, 5) == 0);
            sample();
            checks++;
            if (got_a !== want_a) begin fails++; $display("[TB] FAIL random A cyc %0d: got %b want %b", i, got_a, want_a); end
            checks++;
            if (got_b !== want_b) begin fails++; $display("[TB] FAIL random B cyc %0d: got %b want %b", i, got_b, want_b); end
            advance();
        end
    endtask

    // Test sequence
    initial begin
        for (int k = 0; k < 2; k++) begin
            busy_left[k] = 0; lu_pend[k] = 1'b0; stall_m[k] = 0;
        end
        applyStimulus();
        RST = 1'b1;
        advance();
        test_reset();
        test_load_use();
        test_multi_cycle();
        test_branch_abort();
        test_raw();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
